// File: rtl/dds_pkg.sv
// dds_pkg: shared types and elaboration-time helpers for the DDS wave generator.
package dds_pkg;

    typedef enum logic [1:0] {MODE_SINE, MODE_TRI, MODE_SAW, MODE_SQR} mode_t;

    localparam int     FRAC = 30;
    localparam longint PI_Q = 64'd3373259426;

    function automatic int mid_val(input int dw);
        return 1 << (dw - 1);
    endfunction

    function automatic int amp_val(input int dw);
        return (1 << (dw - 1)) - 1;
    endfunction

    // round(AMP*sin(pi*(2j+1)/2^aw)) via a Q30 Taylor series, so no real math is needed
    function automatic int quarter_entry(input int j, input int aw, input int dw);
        longint x, x2, term, sum;
        x    = (PI_Q * longint'(2 * j + 1)) >>> aw;
        x2   = (x * x) >>> FRAC;
        term = x;
        sum  = x;
        for (int k = 1; k <= 8; k++) begin
            term = -((term * x2) >>> FRAC) / longint'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        return int'((longint'(amp_val(dw)) * sum + (longint'(1) <<< (FRAC - 1))) >>> FRAC);
    endfunction

endpackage

// File: rtl/quarter_sine_rom.sv
// quarter_sine_rom: dual-port synchronous-read quarter-wave sine table.
module quarter_sine_rom
    import dds_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-3:0] i_addr_a,
    input  logic [ADDR_W-3:0] i_addr_b,
    output logic [DATA_W-2:0] o_data_a,
    output logic [DATA_W-2:0] o_data_b
);
    localparam int N = 1 << (ADDR_W - 2);

    logic [DATA_W-2:0] w_rom [N];
    logic [DATA_W-2:0] r_data_a, r_data_b;

    for (genvar g = 0; g < N; g++) begin : g_rom
        localparam int E = quarter_entry(g, ADDR_W, DATA_W);
        assign w_rom[g] = E[DATA_W-2:0];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_data_a <= '0;
            r_data_b <= '0;
        end else begin
            r_data_a <= w_rom[i_addr_a];
            r_data_b <= w_rom[i_addr_b];
        end
    end

    assign o_data_a = r_data_a;
    assign o_data_b = r_data_b;
endmodule

// File: rtl/dds_wave_generator.sv
// dds_wave_generator: phase-accumulator NCO with sine/triangle/saw/square outputs,
// in-phase and quadrature, three pipeline stages after the accumulator.
module dds_wave_generator
    import dds_pkg::*;
#(
    parameter int PHASE_W     = 24,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int SYNC_UPDATE = 1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               en,
    input  logic [PHASE_W-1:0] ftw_in,
    input  logic               ftw_valid,
    output logic               ftw_ready,
    input  logic [ADDR_W-1:0]  phase_off,
    input  logic               phase_clr,
    input  logic [1:0]         mode,
    output logic [DATA_W-1:0]  q,
    output logic [DATA_W-1:0]  q_quad,
    output logic               out_valid
);
    localparam logic [DATA_W-1:0] MID = DATA_W'(mid_val(DATA_W));
    localparam logic [ADDR_W-1:0] QTR = ADDR_W'(1 << (ADDR_W - 2));

    logic [PHASE_W-1:0] r_acc, r_ftw_active, w_sum;
    logic               w_carry, w_wrap;
    logic [ADDR_W-1:0]  w_a, r_a1, r_aq1, r_a2, r_aq2;
    logic [ADDR_W-3:0]  w_idx_a, w_idx_b;
    logic [DATA_W-2:0]  w_ent_a, w_ent_b;
    logic [DATA_W-1:0]  r_q, r_qq;
    mode_t              r_mode1, r_mode2;
    logic               r_en1, r_en2, r_valid;

    assign {w_carry, w_sum} = {1'b0, r_acc} + {1'b0, r_ftw_active};
    assign w_wrap           = phase_clr || (en && w_carry);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_acc <= '0;
        else if (phase_clr)
            r_acc <= '0;
        else if (en)
            r_acc <= w_sum;
    end

    if (SYNC_UPDATE != 0) begin : g_sync
        logic [PHASE_W-1:0] r_pending;
        logic               r_pend_full;
        // the wrap add still uses the old word; the pending one takes over afterwards
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_ftw_active <= '0;
                r_pending    <= '0;
                r_pend_full  <= 1'b0;
            end else if (w_wrap && r_pend_full) begin
                r_ftw_active <= r_pending;
                r_pend_full  <= 1'b0;
            end else if (ftw_valid && !r_pend_full) begin
                r_pending    <= ftw_in;
                r_pend_full  <= 1'b1;
            end
        end
        assign ftw_ready = !r_pend_full;
    end else begin : g_direct
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n)
                r_ftw_active <= '0;
            else if (ftw_valid)
                r_ftw_active <= ftw_in;
        end
        assign ftw_ready = 1'b1;
    end

    assign w_a = r_acc[PHASE_W-1 -: ADDR_W] + phase_off;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_a1    <= '0;
            r_aq1   <= '0;
            r_mode1 <= MODE_SINE;
            r_en1   <= 1'b0;
        end else begin
            r_a1    <= w_a;
            r_aq1   <= w_a + QTR;
            r_mode1 <= mode_t'(mode);
            r_en1   <= en;
        end
    end

    // odd quadrants read the table backwards; the sign comes from the address MSB
    assign w_idx_a = r_a1[ADDR_W-2]  ? ~r_a1[ADDR_W-3:0]  : r_a1[ADDR_W-3:0];
    assign w_idx_b = r_aq1[ADDR_W-2] ? ~r_aq1[ADDR_W-3:0] : r_aq1[ADDR_W-3:0];

    quarter_sine_rom #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rom (
        .clock    (clock),
        .reset_n  (reset_n),
        .i_addr_a (w_idx_a),
        .i_addr_b (w_idx_b),
        .o_data_a (w_ent_a),
        .o_data_b (w_ent_b)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_a2    <= '0;
            r_aq2   <= '0;
            r_mode2 <= MODE_SINE;
            r_en2   <= 1'b0;
        end else begin
            r_a2    <= r_a1;
            r_aq2   <= r_aq1;
            r_mode2 <= r_mode1;
            r_en2   <= r_en1;
        end
    end

    function automatic logic [DATA_W-1:0] shape(input logic [ADDR_W-1:0] a,
                                                 input logic [DATA_W-2:0] ent,
                                                 input mode_t m);
        logic [ADDR_W-2:0]        t;
        logic [ADDR_W+DATA_W-2:0] tw;
        logic [ADDR_W+DATA_W-1:0] sw;
        t  = a[ADDR_W-1] ? ~a[ADDR_W-2:0] : a[ADDR_W-2:0];
        tw = {t, {DATA_W{1'b0}}};
        sw = {a, {DATA_W{1'b0}}};
        return m == MODE_SINE ? (a[ADDR_W-1] ? MID - {1'b0, ent} : MID + {1'b0, ent}) :
               m == MODE_TRI  ? tw[ADDR_W+DATA_W-2 -: DATA_W] :
               m == MODE_SAW  ? sw[ADDR_W+DATA_W-1 -: DATA_W] :
               (a[ADDR_W-1] ? '0 : '1);
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_q     <= MID;
            r_qq    <= MID;
            r_valid <= 1'b0;
        end else begin
            r_q     <= shape(r_a2, w_ent_a, r_mode2);
            r_qq    <= shape(r_aq2, w_ent_b, r_mode2);
            r_valid <= r_en2;
        end
    end

    assign q         = r_q;
    assign q_quad    = r_qq;
    assign out_valid = r_valid;
endmodule

// File: tb/tb_dds_wave_generator.sv
// tb_dds_wave_generator: randomized and directed checks of dds_wave_generator
// against a sample-history model built from the waveform formulas.
module tb_dds_wave_generator;
    localparam real PI = 3.14159265358979;

    logic        clock = 0, reset_n = 0, en = 0, ftw_valid = 0, phase_clr = 0;
    logic [23:0] ftw_in = 0;
    logic [7:0]  phase_off = 0;
    logic [1:0]  mode = 0;
    logic        ftw_ready, out_valid;
    logic [7:0]  q, q_quad;

    dds_wave_generator #(.PHASE_W(24), .ADDR_W(8), .DATA_W(8), .SYNC_UPDATE(1)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .en        (en),
        .ftw_in    (ftw_in),
        .ftw_valid (ftw_valid),
        .ftw_ready (ftw_ready),
        .phase_off (phase_off),
        .phase_clr (phase_clr),
        .mode      (mode),
        .q         (q),
        .q_quad    (q_quad),
        .out_valid (out_valid)
    );

    always #5 clock = ~clock;

    typedef struct {bit rst; int a; int md; bit en;} smp_t;
    smp_t        hist[$];
    int unsigned m_acc, m_ftw, m_pend;
    bit          m_pfull, e_v, e_rdy;
    int          e_q, e_qq, n_vec, n_err;

    function automatic int wave(input int a, input int md);
        real r;
        int  s;
        r = 127.0 * $sin(2.0 * PI * (real'(a) + 0.5) / 256.0);
        s = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
        return md == 0 ? 128 + s : md == 1 ? (a < 128 ? 2 * a : 2 * (255 - a)) :
               md == 2 ? a : (a < 128 ? 255 : 0);
    endfunction

    task automatic model_reset();
        m_acc = 0; m_ftw = 0; m_pend = 0; m_pfull = 0;
        hist.delete();
        hist.push_back('{1, 0, 0, 0});
        hist.push_back('{1, 0, 0, 0});
        e_v = 0; e_rdy = 1; e_q = -1; e_qq = -1;
    endtask

    // one clock: the sample of this edge reaches q two edges later
    task automatic tick();
        smp_t        s;
        int unsigned sum;
        bit          wrap;
        @(posedge clock);
        s.rst = 0;
        s.a   = int'((m_acc >> 16) + phase_off) % 256;
        s.md  = int'(mode);
        s.en  = en;
        hist.push_back(s);
        if (hist.size() > 3) void'(hist.pop_front());
        sum  = m_acc + m_ftw;
        wrap = phase_clr || (en && sum >= 32'h100_0000);
        if (phase_clr) m_acc = 0;
        else if (en) m_acc = sum & 32'hFF_FFFF;
        if (wrap && m_pfull) begin
            m_ftw = m_pend; m_pfull = 0;
        end else if (ftw_valid && !m_pfull) begin
            m_pend = ftw_in; m_pfull = 1;
        end
        e_rdy = !m_pfull;
        e_v   = !hist[0].rst && hist[0].en;
        e_q   = hist[0].rst ? -1 : wave(hist[0].a, hist[0].md);
        e_qq  = hist[0].rst ? -1 : wave((hist[0].a + 64) % 256, hist[0].md);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 0;
        repeat (2) @(posedge clock);
        #1;
        n_vec++; if (q !== 8'd128) begin n_err++; $display("FAIL reset_q got %0d want 128", q); end
        n_vec++; if (q_quad !== 8'd128) begin n_err++; $display("FAIL reset_qq got %0d want 128", q_quad); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_vec++; if (ftw_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", ftw_ready); end
        reset_n = 1;
        model_reset();
    endtask

    task automatic test_sine_sweep();
        int k;
        en = 1; mode = 0; phase_off = 0; ftw_in = 24'd65536; ftw_valid = 1;
        tick();
        ftw_valid = 0;
        n_vec++; if (ftw_ready !== 1'b0) begin n_err++; $display("FAIL sweep_pending_ready got %b want 0", ftw_ready); end
        phase_clr = 1;
        tick();
        phase_clr = 0;
        n_vec++; if (ftw_ready !== 1'b1) begin n_err++; $display("FAIL sweep_apply_ready got %b want 1", ftw_ready); end
        for (int i = 0; i < 300; i++) begin
            tick();
            n_vec++; if (out_valid !== e_v) begin n_err++; $display("FAIL sweep_valid @%0t got %b want %b", $time, out_valid, e_v); end
            n_vec++; if (ftw_ready !== e_rdy) begin n_err++; $display("FAIL sweep_ready @%0t got %b want %b", $time, ftw_ready, e_rdy); end
            if (e_q >= 0) begin
                n_vec++; if (q !== 8'(e_q)) begin n_err++; $display("FAIL sweep_q @%0t got %0d want %0d", $time, q, e_q); end
                n_vec++; if (q_quad !== 8'(e_qq)) begin n_err++; $display("FAIL sweep_qq @%0t got %0d want %0d", $time, q_quad, e_qq); end
            end
            if (!hist[0].rst && hist[0].md == 0) begin
                k = hist[0].a;
                k = k == 0 ? 130 : k == 1 ? 133 : (k == 63 || k == 64) ? 255 : k == 128 ? 126 : k == 191 ? 1 : -1;
                if (k >= 0) begin
                    n_vec++; if (q !== 8'(k)) begin n_err++; $display("FAIL sweep_point a=%0d got %0d want %0d", hist[0].a, q, k); end
                end
                if (hist[0].a == 0) begin
                    n_vec++; if (q_quad !== 8'd255) begin n_err++; $display("FAIL sweep_quad0 got %0d want 255", q_quad); end
                end
            end
        end
    endtask

    task automatic test_modes();
        int want;
        for (int m = 1; m < 4; m++) begin
            for (int p = 127; p < 129; p++) begin
                mode = 2'(m); en = 0; phase_off = 8'(p); phase_clr = 1;
                tick();
                phase_clr = 0;
                repeat (3) tick();
                want = m == 1 ? 254 : m == 2 ? p : (p == 127 ? 255 : 0);
                n_vec++; if (q !== 8'(want)) begin n_err++; $display("FAIL mode%0d_a%0d got %0d want %0d", m, p, q, want); end
                n_vec++; if (q !== 8'(e_q)) begin n_err++; $display("FAIL mode%0d_model got %0d want %0d", m, q, e_q); end
                n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mode%0d_valid got %b want 0", m, out_valid); end
            end
        end
    endtask

    task automatic test_sync_update();
        mode = 2; en = 1; phase_off = 0; phase_clr = 1;
        tick();
        phase_clr = 0;
        repeat (20) tick();
        ftw_in = 24'd131072; ftw_valid = 1;
        tick();
        ftw_valid = 0;
        n_vec++; if (ftw_ready !== 1'b0) begin n_err++; $display("FAIL sync_busy got %b want 0", ftw_ready); end
        for (int i = 0; i < 280 && m_pfull; i++) begin
            tick();
            n_vec++; if (ftw_ready !== e_rdy) begin n_err++; $display("FAIL sync_ready @%0t got %b want %b", $time, ftw_ready, e_rdy); end
            n_vec++; if (q !== 8'(e_q)) begin n_err++; $display("FAIL sync_q @%0t got %0d want %0d", $time, q, e_q); end
        end
        n_vec++; if (m_pfull) begin n_err++; $display("FAIL sync_timeout got pending want applied"); end
        for (int i = 0; i < 12; i++) begin
            tick();
            n_vec++; if (out_valid !== e_v) begin n_err++; $display("FAIL sync_valid @%0t got %b want %b", $time, out_valid, e_v); end
            n_vec++; if (ftw_ready !== e_rdy) begin n_err++; $display("FAIL sync_ready2 @%0t got %b want %b", $time, ftw_ready, e_rdy); end
            n_vec++; if (q !== 8'(e_q)) begin n_err++; $display("FAIL sync_q2 @%0t got %0d want %0d", $time, q, e_q); end
            n_vec++; if (q_quad !== 8'(e_qq)) begin n_err++; $display("FAIL sync_qq2 @%0t got %0d want %0d", $time, q_quad, e_qq); end
        end
    endtask

    task automatic test_clr_apply();
        mode = 0; en = 1; ftw_in = 24'($urandom_range(1, 1 << 20)); ftw_valid = 1;
        tick();
        ftw_valid = 0;
        tick();
        phase_clr = 1;
        tick();
        phase_clr = 0;
        n_vec++; if (ftw_ready !== 1'b1) begin n_err++; $display("FAIL clr_ready got %b want 1", ftw_ready); end
        for (int i = 0; i < 8; i++) begin
            tick();
            n_vec++; if (out_valid !== e_v) begin n_err++; $display("FAIL clr_valid @%0t got %b want %b", $time, out_valid, e_v); end
            n_vec++; if (q !== 8'(e_q)) begin n_err++; $display("FAIL clr_q @%0t got %0d want %0d", $time, q, e_q); end
            n_vec++; if (q_quad !== 8'(e_qq)) begin n_err++; $display("FAIL clr_qq @%0t got %0d want %0d", $time, q_quad, e_qq); end
        end
    endtask

    task automatic test_en_toggle();
        mode = 0; ftw_in = 24'd65536; ftw_valid = 1;
        tick();
        ftw_valid = 0; phase_clr = 1;
        tick();
        phase_clr = 0;
        for (int i = 0; i < 25; i++) begin
            en = !(i >= 10 && i < 15);
            tick();
            n_vec++; if (out_valid !== e_v) begin n_err++; $display("FAIL en_valid @%0t got %b want %b", $time, out_valid, e_v); end
            n_vec++; if (q !== 8'(e_q)) begin n_err++; $display("FAIL en_q @%0t got %0d want %0d", $time, q, e_q); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            en        = ($urandom % 4) != 0;
            phase_clr = ($urandom % 64) == 0;
            ftw_valid = ($urandom % 8) == 0;
            ftw_in    = 24'($urandom_range(0, 24'hFF_FFFF));
            if ($urandom % 16 == 0) mode = 2'($urandom);
            if ($urandom % 32 == 0) phase_off = 8'($urandom);
            tick();
            n_vec++; if (out_valid !== e_v) begin n_err++; $display("FAIL rnd_valid @%0t got %b want %b", $time, out_valid, e_v); end
            n_vec++; if (ftw_ready !== e_rdy) begin n_err++; $display("FAIL rnd_ready @%0t got %b want %b", $time, ftw_ready, e_rdy); end
            n_vec++; if (q !== 8'(e_q)) begin n_err++; $display("FAIL rnd_q @%0t got %0d want %0d", $time, q, e_q); end
            n_vec++; if (q_quad !== 8'(e_qq)) begin n_err++; $display("FAIL rnd_qq @%0t got %0d want %0d", $time, q_quad, e_qq); end
        end
        ftw_valid = 0; phase_clr = 0;
    endtask

    task automatic test_async_reset();
        en = 1; mode = 0; phase_off = 8'd10;
        repeat (5) tick();
        #3 reset_n = 0;
        #1;
        n_vec++; if (q !== 8'd128) begin n_err++; $display("FAIL areset_q got %0d want 128", q); end
        n_vec++; if (q_quad !== 8'd128) begin n_err++; $display("FAIL areset_qq got %0d want 128", q_quad); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL areset_valid got %b want 0", out_valid); end
        n_vec++; if (ftw_ready !== 1'b1) begin n_err++; $display("FAIL areset_ready got %b want 1", ftw_ready); end
        @(posedge clock);
        #2 reset_n = 1;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            tick();
            n_vec++; if (out_valid !== e_v) begin n_err++; $display("FAIL post_valid @%0t got %b want %b", $time, out_valid, e_v); end
            if (e_q >= 0) begin
                n_vec++; if (q !== 8'(e_q)) begin n_err++; $display("FAIL post_q @%0t got %0d want %0d", $time, q, e_q); end
                n_vec++; if (q !== 8'(wave(10, 0))) begin n_err++; $display("FAIL post_hold @%0t got %0d want %0d", $time, q, wave(10, 0)); end
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        model_reset();
        test_reset();
        test_sine_sweep();
        test_modes();
        test_sync_update();
        test_clr_apply();
        test_en_toggle();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/dds_wave_generator.md
Name: dds_wave_generator

Overview:
- Parametrised numerically controlled oscillator: phase accumulator drives a quarter-wave sine ROM and arithmetic generators for triangle, sawtooth and square waveforms.
- Produces an in-phase output and a quadrature output (+90°) in offset-binary form.
- Frequency tuning word is loaded through a valid/ready handshake, with optional phase-continuous update at accumulator wrap.
- Feeds DAC/PWM stages and test-tone paths in the signal-generation datapath.

Parameters:
- PHASE_W, 24, accumulator width; legal PHASE_W >= ADDR_W.
- ADDR_W, 8, full-cycle waveform address width; ROM holds 2^(ADDR_W-2) entries; legal ADDR_W >= 4.
- DATA_W, 8, output sample width; legal range 4..16.
- SYNC_UPDATE, 1, 1 = a new FTW takes effect only at an accumulator wrap; 0 = it takes effect on the next cycle.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- en  in  1  accumulator advance enable
- ftw_in  in  PHASE_W  frequency tuning word
- ftw_valid  in  1  ftw_in valid
- ftw_ready  out  1  tuning word can be accepted
- phase_off  in  ADDR_W  phase offset added to the waveform address
- phase_clr  in  1  synchronous accumulator clear
- mode  in  2  0 sine, 1 triangle, 2 sawtooth, 3 square
- q  out  DATA_W  in-phase sample
- q_quad  out  DATA_W  quadrature sample (address + 2^(ADDR_W-2))
- out_valid  out  1  q/q_quad carry an enabled sample

Behaviour:
- Reset values (async, applies at any time including mid-operation): acc=0, ftw_active=0, pending empty, ftw_ready=1, q=q_quad=MID, out_valid=0.
  - MID=2^(DATA_W-1), AMP=2^(DATA_W-1)-1.
- Accumulator stage S0:
  - If phase_clr: acc<=0.
  - Else if en: acc<=acc+ftw_active, mod 2^PHASE_W.
  - wrap = carry out of that add, or phase_clr.
- Handshake, SYNC_UPDATE=0:
  - ftw_ready is constantly 1.
  - On ftw_valid, ftw_active<=ftw_in; the new value is used from the next cycle.
- Handshake, SYNC_UPDATE=1:
  - On ftw_valid&&ftw_ready: latch the word into pending and drive ftw_ready<=0.
  - On the first wrap cycle with pending full: the add in that cycle still uses the old ftw_active; then ftw_active<=pending and ftw_ready<=1.
  - Acceptance and wrap in the same cycle: the word is not applied that cycle; it waits for the next wrap.
  - phase_clr counts as a wrap, so a pending word is applied in the same cycle acc clears.
- Stage S1, registered:
  - a = acc[PHASE_W-1 -: ADDR_W] + phase_off, mod 2^ADDR_W.
  - aq = a + 2^(ADDR_W-2).
  - mode and en are captured with the address, so a mode change never mixes waveforms within one sample.
- Stage S2, registered: ROM read for both addresses.
  - Quadrant = top 2 bits; idx = low ADDR_W-2 bits.
  - Odd quadrant: idx = ~idx.
  - Quadrant >= 2: negate flag set.
- Stage S3, registered: combine.
  - Sine: MID+entry, or MID-entry when negate.
  - ROM entry j = round(AMP*sin(2π(j+0.5)/2^ADDR_W)). The half-sample offset gives exact mirror symmetry.
  - Triangle: t = a[MSB] ? ~a[ADDR_W-2:0] : a[ADDR_W-2:0], left-justified into DATA_W (truncate low bits or zero-pad).
  - Sawtooth: a left-justified into DATA_W.
  - Square: a[MSB] ? 0 : 2^DATA_W-1.
- Latency: an acc value appears on q exactly 3 cycles later; out_valid = en delayed 3 cycles.
- The pipeline always flows. en=0 freezes the phase only, and held samples repeat with out_valid=0.

Decomposition:
- dds_pkg holds:
  - the mode enum (MODE_SINE, MODE_TRI, MODE_SAW, MODE_SQR);
  - the MID/AMP constant functions;
  - the quarter-table generation function used at elaboration.
- Sub-module quarter_sine_rom: two synchronous read ports, 2^(ADDR_W-2) x (DATA_W-1) entries, filled from the dds_pkg function.

Test Plan (PHASE_W=24, ADDR_W=8, DATA_W=8):
- Reset, ftw 65536 accepted, en=1, mode sine:
  - q sequence starts 130, 133, ...
  - phase address 63 -> q 255; address 64 -> 255; address 128 -> 126; address 191 -> 1.
  - q_quad at phase 0 = 255.
  - out_valid rises 3 cycles after acc first advances.
- Mode triangle / saw / square at phase address 127:
  - q = 254 / 127 / 255.
  - At address 128: 254 / 128 / 0.
- SYNC_UPDATE=1, ftw 65536 running, new ftw 131072 offered:
  - ftw_ready=0 until acc wraps.
  - Address step changes from 1 to 2 only after address 255->0.
  - ftw_ready returns to 1 on the apply cycle.
- phase_clr in the same cycle as pending FTW apply: acc=0 and the new FTW are both in effect the next cycle; no sample glitch in the mode pipeline.
- en toggled low for 5 cycles: the address holds, out_valid=0 for those 5 samples 3 cycles later, and the sequence resumes without skip.
- reset_n pulsed low mid-sweep, asynchronously between edges: outputs go to 128/128/0 immediately; after release acc=0 and ftw_active=0 until a new handshake.
